// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch unit,
// ready/data back from a variable-latency instruction memory.
interface mips_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  // Fetch unit side: issues requests, consumes returned words
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  // Memory side: accepts requests, returns words
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch / next-PC stage.
// Holds the PC, fetches one word per instruction over a req/ready bus,
// presents it to the controller in EXEC, then applies the controller's
// jump/branch decision to form the next PC. A fetch that takes too long
// or a misaligned jr target parks the unit in a sticky ERR state.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  mips_fetch_unit_if.master        imemBus,
  input  logic                     exec_hold,
  input  logic                     Jump,
  input  logic                     Jumpr,
  input  logic                     BranchJump,
  input  logic [31:0]              jr_target,
  output logic [31:0]              instr,
  output logic [5:0]               OpCode,
  output logic [5:0]               Func,
  output logic                     instr_valid,
  output logic [31:0]              pc,
  output logic [31:0]              pc_plus4,
  output logic [31:0]              retired,
  output logic                     fetch_err
);

  // FSM encoding kept as plain constants for compatibility with older tools
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  // Counter is wide enough to hold FETCH_TIMEOUT-1 even when it is 1
  localparam int unsigned CntW = $clog2(FETCH_TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FETCH_TIMEOUT - 1);

  logic [1:0]      stateReg,   stateNext;
  logic [31:0]     pcReg,      pcNext;
  logic [31:0]     instrReg,   instrNext;
  logic [31:0]     retiredReg, retiredNext;
  logic [CntW-1:0] toCntReg,   toCntNext;

  logic [31:0] pcPlus4;
  logic [31:0] jumpTarget;
  logic [31:0] branchOffset;
  logic [31:0] branchTarget;
  logic [31:0] targetPc;
  logic        jrMisaligned;

  // Candidate next-PC values; all arithmetic wraps modulo 2^32
  always_comb begin
    pcPlus4      = pcReg + 32'd4;
    jumpTarget   = {pcPlus4[31:28], instrReg[25:0], 2'b00};
    branchOffset = {{14{instrReg[15]}}, instrReg[15:0], 2'b00};
    branchTarget = pcPlus4 + branchOffset;
    jrMisaligned = Jumpr && (jr_target[1:0] != 2'b00);
  end

  // Next-PC select: jr beats j beats taken branch beats sequential
  always_comb begin
    if (Jumpr) begin
      targetPc = jr_target;
    end else if (Jump) begin
      targetPc = jumpTarget;
    end else if (BranchJump) begin
      targetPc = branchTarget;
    end else begin
      targetPc = pcPlus4;
    end
  end

  // FSM next-state and datapath update decisions
  always_comb begin
    stateNext   = stateReg;
    pcNext      = pcReg;
    instrNext   = instrReg;
    retiredNext = retiredReg;
    toCntNext   = toCntReg;
    case (stateReg)
      IDLE: begin
        stateNext = REQ;
      end
      REQ: begin
        // A word arriving on the last allowed cycle still counts as success
        if (imemBus.imem_ready) begin
          instrNext = imemBus.imem_rdata;
          toCntNext = '0;
          stateNext = EXEC;
        end else if (toCntReg == CntLast) begin
          toCntNext = '0;
          stateNext = ERR;
        end else begin
          toCntNext = toCntReg + CntW'(1);
        end
      end
      EXEC: begin
        // Controller flags are only acted on once the datapath releases the stall
        if (!exec_hold) begin
          if (jrMisaligned) begin
            stateNext = ERR;
          end else begin
            pcNext      = targetPc;
            retiredNext = retiredReg + 32'd1;
            stateNext   = REQ;
          end
        end
      end
      ERR: begin
        // Sticky: only reset leaves this state
        stateNext = ERR;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= IDLE;
      pcReg      <= RESET_PC;
      instrReg   <= 32'd0;
      retiredReg <= 32'd0;
      toCntReg   <= '0;
    end else begin
      stateReg   <= stateNext;
      pcReg      <= pcNext;
      instrReg   <= instrNext;
      retiredReg <= retiredNext;
      toCntReg   <= toCntNext;
    end
  end

  // Request is masked by rst so it drops in the cycle reset is sampled,
  // which also means a ready arriving with reset is never accepted
  assign imemBus.imem_req  = (stateReg == REQ) && !rst;
  assign imemBus.imem_addr = pcReg;

  assign instr       = instrReg;
  assign OpCode      = instrReg[31:26];
  assign Func        = instrReg[5:0];
  assign instr_valid = (stateReg == EXEC);
  assign pc          = pcReg;
  assign pc_plus4    = pcPlus4;
  assign retired     = retiredReg;
  assign fetch_err   = (stateReg == ERR);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit. Inputs change and outputs are sampled
// on the falling clock edge; expected values are hand-computed constants.
module tb_mips_fetch_unit;

  logic        clk;
  logic        rst;
  logic        exec_hold;
  logic        Jump;
  logic        Jumpr;
  logic        BranchJump;
  logic [31:0] jr_target;
  logic [31:0] instr;
  logic [5:0]  OpCode;
  logic [5:0]  Func;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;
  logic        fetch_err;

  int total;
  int bad;

  mips_fetch_unit_if imemBus ();

  mips_fetch_unit #(
    .RESET_PC     (32'h0000_0000),
    .FETCH_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imemBus    (imemBus),
    .exec_hold  (exec_hold),
    .Jump       (Jump),
    .Jumpr      (Jumpr),
    .BranchJump (BranchJump),
    .jr_target  (jr_target),
    .instr      (instr),
    .OpCode     (OpCode),
    .Func       (Func),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .retired    (retired),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle at the falling edge
  task automatic stepClk();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset for one cycle; leaves the unit in IDLE with rst released
  task automatic doReset();
    rst = 1'b1;
    exec_hold = 1'b0; Jump = 1'b0; Jumpr = 1'b0; BranchJump = 1'b0; jr_target = 32'd0;
    imemBus.imem_ready = 1'b0; imemBus.imem_rdata = 32'd0;
    stepClk();
    rst = 1'b0;
  endtask

  // Reset and advance into the first REQ cycle
  task automatic goReq();
    doReset();
    stepClk();
  endtask

  // From REQ: memory answers immediately, unit moves to EXEC
  task automatic doFetch(input logic [31:0] w);
    imemBus.imem_ready = 1'b1;
    imemBus.imem_rdata = w;
    stepClk();
    imemBus.imem_ready = 1'b0;
    imemBus.imem_rdata = 32'd0;
  endtask

  // From EXEC: apply controller decision for one cycle
  task automatic doExec(input logic j, input logic jr, input logic bj, input logic [31:0] tgt);
    exec_hold = 1'b0; Jump = j; Jumpr = jr; BranchJump = bj; jr_target = tgt;
    stepClk();
    Jump = 1'b0; Jumpr = 1'b0; BranchJump = 1'b0; jr_target = 32'd0;
  endtask

  task automatic test_reset_and_sequential();
    rst = 1'b1;
    exec_hold = 1'b0; Jump = 1'b0; Jumpr = 1'b0; BranchJump = 1'b0; jr_target = 32'd0;
    imemBus.imem_ready = 1'b1; imemBus.imem_rdata = 32'd0;
    stepClk();
    stepClk();
    total++; if (imemBus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got=%b want=0", imemBus.imem_req); end
    total++; if (imemBus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got=%h want=%h", imemBus.imem_addr, 32'h0); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got=%h want=%h", pc, 32'h0); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL rst_pc_plus4: got=%h want=%h", pc_plus4, 32'h4); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got=%h want=%h", instr, 32'h0); end
    total++; if (retired !== 32'h0) begin bad++; $display("FAIL rst_retired: got=%h want=%h", retired, 32'h0); end
    total++; if ({instr_valid, fetch_err} !== 2'b00) begin bad++; $display("FAIL rst_flags: got=%b want=00", {instr_valid, fetch_err}); end
    rst = 1'b0;
    stepClk();
    total++; if ({imemBus.imem_req, instr_valid} !== 2'b10) begin bad++; $display("FAIL seq_first_req: got=%b want=10", {imemBus.imem_req, instr_valid}); end
    for (int i = 0; i < 3; i++) begin
      total++; if (imemBus.imem_addr !== 32'(4 * i)) begin bad++; $display("FAIL seq_addr%0d: got=%h want=%h", i, imemBus.imem_addr, 32'(4 * i)); end
      stepClk();
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d: got=%b want=1", i, instr_valid); end
      stepClk();
    end
    total++; if (retired !== 32'd3) begin bad++; $display("FAIL seq_retired: got=%0d want=3", retired); end
    total++; if (imemBus.imem_addr !== 32'hC) begin bad++; $display("FAIL seq_addr_after: got=%h want=%h", imemBus.imem_addr, 32'hC); end
    imemBus.imem_ready = 1'b0;
    $display("test_reset_and_sequential: retired=%0d addr=%h", retired, imemBus.imem_addr);
  endtask

  // Fetch two nops so the unit sits in EXEC of a beq at pc=8
  task automatic reachBeqAt8();
    goReq();
    doFetch(32'h0); doExec(1'b0, 1'b0, 1'b0, 32'h0);
    doFetch(32'h0); doExec(1'b0, 1'b0, 1'b0, 32'h0);
    doFetch(32'h1000_0003);
  endtask

  task automatic test_branch();
    reachBeqAt8();
    total++; if (pc !== 32'h8) begin bad++; $display("FAIL br_pc: got=%h want=%h", pc, 32'h8); end
    total++; if ({OpCode, Func} !== {6'd4, 6'd3}) begin bad++; $display("FAIL br_decode: got=%h/%h want=04/03", OpCode, Func); end
    doExec(1'b0, 1'b0, 1'b1, 32'h0);
    total++; if (imemBus.imem_addr !== 32'h18) begin bad++; $display("FAIL br_taken: got=%h want=%h", imemBus.imem_addr, 32'h18); end
    // Negative offset -1 word from pc=0x18: 0x1C - 4 = 0x18
    doFetch(32'h1000_FFFF);
    doExec(1'b0, 1'b0, 1'b1, 32'h0);
    total++; if (imemBus.imem_addr !== 32'h18) begin bad++; $display("FAIL br_negative: got=%h want=%h", imemBus.imem_addr, 32'h18); end
    reachBeqAt8();
    doExec(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (imemBus.imem_addr !== 32'hC) begin bad++; $display("FAIL br_not_taken: got=%h want=%h", imemBus.imem_addr, 32'hC); end
    $display("test_branch: addr=%h", imemBus.imem_addr);
  endtask

  task automatic test_jump();
    goReq();
    doFetch(32'h0);
    doExec(1'b0, 1'b1, 1'b0, 32'h4000_0000);
    total++; if (imemBus.imem_addr !== 32'h4000_0000) begin bad++; $display("FAIL j_jr_setup: got=%h want=%h", imemBus.imem_addr, 32'h4000_0000); end
    doFetch(32'h0800_0010);
    // Jump must win over a simultaneous branch (branch would give 0x40000044)
    doExec(1'b1, 1'b0, 1'b1, 32'h0);
    total++; if (imemBus.imem_addr !== 32'h4000_0040) begin bad++; $display("FAIL j_target: got=%h want=%h", imemBus.imem_addr, 32'h4000_0040); end
    doFetch(32'h0800_0010);
    doExec(1'b1, 1'b1, 1'b0, 32'h100);
    total++; if (imemBus.imem_addr !== 32'h100) begin bad++; $display("FAIL j_jr_priority: got=%h want=%h", imemBus.imem_addr, 32'h100); end
    doFetch(32'h0);
    doExec(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL j_wrap_plus4: got=%h want=%h", pc_plus4, 32'h0); end
    doFetch(32'h0);
    doExec(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL j_wrap_pc: got=%h want=%h", pc, 32'h0); end
    total++; if (retired !== 32'd5) begin bad++; $display("FAIL j_retired: got=%0d want=5", retired); end
    $display("test_jump: pc=%h retired=%0d", pc, retired);
  endtask

  task automatic test_timeout();
    logic early;
    goReq();
    early = 1'b0;
    for (int k = 1; k < 16; k++) begin
      stepClk();
      if (imemBus.imem_req !== 1'b1 || fetch_err !== 1'b0) early = 1'b1;
    end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL to_early_err: got=%b want=0", early); end
    stepClk();
    total++; if ({fetch_err, imemBus.imem_req, instr_valid} !== 3'b100) begin bad++; $display("FAIL to_err: got=%b want=100", {fetch_err, imemBus.imem_req, instr_valid}); end
    imemBus.imem_ready = 1'b1; imemBus.imem_rdata = 32'h1234_5678; Jumpr = 1'b1; jr_target = 32'h40;
    stepClk(); stepClk(); stepClk();
    imemBus.imem_ready = 1'b0; Jumpr = 1'b0; jr_target = 32'h0;
    total++; if ({fetch_err, pc, instr} !== {1'b1, 32'h0, 32'h0}) begin bad++; $display("FAIL to_sticky: got=%b/%h/%h want=1/0/0", fetch_err, pc, instr); end
    // Ready on the 16th REQ cycle wins, and the counter restarts per fetch
    goReq();
    for (int k = 1; k < 16; k++) stepClk();
    doFetch(32'hABCD_0001);
    total++; if ({instr_valid, fetch_err, instr} !== {2'b10, 32'hABCD_0001}) begin bad++; $display("FAIL to_last_ok: got=%b%b/%h want=10/abcd0001", instr_valid, fetch_err, instr); end
    doExec(1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k < 16; k++) stepClk();
    doFetch(32'h0);
    total++; if ({instr_valid, fetch_err} !== 2'b10) begin bad++; $display("FAIL to_cnt_restart: got=%b want=10", {instr_valid, fetch_err}); end
    $display("test_timeout: fetch_err=%b pc=%h", fetch_err, pc);
  endtask

  task automatic test_exec_hold();
    logic moved;
    goReq();
    doFetch(32'h0); doExec(1'b0, 1'b0, 1'b0, 32'h0);
    doFetch(32'h0000_0020);
    moved = 1'b0;
    exec_hold = 1'b1; BranchJump = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stepClk();
      if (instr_valid !== 1'b1 || pc !== 32'h4 || retired !== 32'd1) moved = 1'b1;
    end
    BranchJump = 1'b0;
    total++; if (moved !== 1'b0) begin bad++; $display("FAIL hold_stable: got=%b want=0", moved); end
    exec_hold = 1'b0;
    stepClk();
    total++; if ({retired, pc, imemBus.imem_req} !== {32'd2, 32'h8, 1'b1}) begin bad++; $display("FAIL hold_release: got=%0d/%h/%b want=2/8/1", retired, pc, imemBus.imem_req); end
    // Controller flags outside EXEC have no effect
    Jumpr = 1'b1; jr_target = 32'h200;
    stepClk();
    Jumpr = 1'b0; jr_target = 32'h0;
    total++; if (pc !== 32'h8) begin bad++; $display("FAIL hold_flags_ignored: got=%h want=%h", pc, 32'h8); end
    $display("test_exec_hold: pc=%h retired=%0d", pc, retired);
  endtask

  task automatic test_reset_midfetch();
    // Continues from REQ at pc=8, retired=2
    rst = 1'b1;
    imemBus.imem_ready = 1'b1; imemBus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (imemBus.imem_req !== 1'b0) begin bad++; $display("FAIL mid_req_drop: got=%b want=0", imemBus.imem_req); end
    stepClk();
    rst = 1'b0;
    #1;
    total++; if ({pc, retired, instr} !== {32'h0, 32'h0, 32'h0}) begin bad++; $display("FAIL mid_state: got=%h/%h/%h want=0/0/0", pc, retired, instr); end
    total++; if ({imemBus.imem_req, instr_valid, fetch_err} !== 3'b000) begin bad++; $display("FAIL mid_idle: got=%b want=000", {imemBus.imem_req, instr_valid, fetch_err}); end
    stepClk();
    total++; if ({imemBus.imem_req, instr_valid} !== 2'b10) begin bad++; $display("FAIL mid_late_ready: got=%b want=10", {imemBus.imem_req, instr_valid}); end
    imemBus.imem_rdata = 32'h0;
    stepClk();
    imemBus.imem_ready = 1'b0;
    doExec(1'b0, 1'b1, 1'b0, 32'h102);
    total++; if ({fetch_err, pc, retired} !== {1'b1, 32'h0, 32'h0}) begin bad++; $display("FAIL mid_jr_misaligned: got=%b/%h/%h want=1/0/0", fetch_err, pc, retired); end
    $display("test_reset_midfetch: fetch_err=%b", fetch_err);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset_and_sequential();
    test_branch();
    test_jump();
    test_timeout();
    test_exec_hold();
    test_reset_midfetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
